// File: rtl/fft8_bfly_sched.sv
// Load/compute/unload sequencer and in-place storage for an 8-point radix-2 DIT FFT
// driving one external combinational butterfly. Define FFT_STAGE_SCALE_EN to halve every stage result.
module fft8_bfly_sched #(
  parameter int width   = 8,
  parameter int decimal = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_re,
  input  logic [width-1:0] in_im,
  output logic [width-1:0] bf_er,
  output logic [width-1:0] bf_ei,
  output logic [width-1:0] bf_or,
  output logic [width-1:0] bf_oi,
  output logic [width-1:0] bf_wr,
  output logic [width-1:0] bf_wi,
  input  logic [width-1:0] bf_o0r,
  input  logic [width-1:0] bf_o0i,
  input  logic [width-1:0] bf_o1r,
  input  logic [width-1:0] bf_o1i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_re,
  output logic [width-1:0] out_im,
  output logic             out_last
);

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  // round(sqrt(v)) by exhaustive search; only evaluated at elaboration
  function automatic int isqrt_round(input int v);
    int n;
    n = 0;
    while ((n + 1) * (n + 1) <= v) n++;
    if (v - n * n > n) n++;
    return n;
  endfunction

  localparam int one_i   = 1 << decimal;
  localparam int c45_i   = isqrt_round(1 << (2 * decimal - 1));
  localparam int mone_i  = -one_i;
  localparam int mc45_i  = -c45_i;
  localparam logic [width-1:0] w_one  = one_i[width-1:0];
  localparam logic [width-1:0] w_c45  = c45_i[width-1:0];
  localparam logic [width-1:0] w_mone = mone_i[width-1:0];
  localparam logic [width-1:0] w_mc45 = mc45_i[width-1:0];

  state_t state, state_next;
  logic [2:0] cnt, cnt_next;
  logic [1:0] stage, stage_next;
  logic [1:0] bfly, bfly_next;
  logic [2:0] addr_lo, addr_hi;
  logic [1:0] tw_k;
  logic [width-1:0] mem_re [8];
  logic [width-1:0] mem_im [8];
  logic [width-1:0] wb0_re, wb0_im, wb1_re, wb1_im;

`ifdef FFT_STAGE_SCALE_EN
  assign wb0_re = $signed(bf_o0r) >>> 1;
  assign wb0_im = $signed(bf_o0i) >>> 1;
  assign wb1_re = $signed(bf_o1r) >>> 1;
  assign wb1_im = $signed(bf_o1i) >>> 1;
`else
  assign wb0_re = bf_o0r;
  assign wb0_im = bf_o0i;
  assign wb1_re = bf_o1r;
  assign wb1_im = bf_o1i;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD;
      cnt   <= '0;
      stage <= '0;
      bfly  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      stage <= stage_next;
      bfly  <= bfly_next;
    end
  end

  // Closed forms of a = ((b>>s)<<(s+1)) + pos and k = pos<<(2-s) for each stage
  always_comb begin
    addr_lo = '0;
    tw_k    = '0;
    case (stage)
      2'd0:    begin addr_lo = {bfly, 1'b0};             tw_k = 2'd0;            end
      2'd1:    begin addr_lo = {bfly[1], 1'b0, bfly[0]}; tw_k = {bfly[0], 1'b0}; end
      default: begin addr_lo = {1'b0, bfly};             tw_k = bfly;            end
    endcase
    addr_hi = addr_lo | (3'd1 << stage);
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stage_next = stage;
    bfly_next  = bfly;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_re     = '0;
    out_im     = '0;
    bf_er      = '0;
    bf_ei      = '0;
    bf_or      = '0;
    bf_oi      = '0;
    bf_wr      = '0;
    bf_wi      = '0;
    case (state)
      LOAD: begin
        in_ready = rst_n;
        if (in_valid && in_ready) begin
          cnt_next = cnt + 3'd1;
          if (cnt == 3'd7) state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        if (rst_n) begin
          bf_er = mem_re[addr_lo];
          bf_ei = mem_im[addr_lo];
          bf_or = mem_re[addr_hi];
          bf_oi = mem_im[addr_hi];
          case (tw_k)
            2'd0:    begin bf_wr = w_one;  bf_wi = '0;     end
            2'd1:    begin bf_wr = w_c45;  bf_wi = w_mc45; end
            2'd2:    begin bf_wr = '0;     bf_wi = w_mone; end
            default: begin bf_wr = w_mc45; bf_wi = w_mc45; end
          endcase
        end
        bfly_next = bfly + 2'd1;
        if (bfly == 2'd3) begin
          stage_next = stage + 2'd1;
          if (stage == 2'd2) begin
            stage_next = '0;
            state_next = UNLOAD;
          end
        end
      end
      UNLOAD: begin
        if (rst_n) begin
          out_valid = 1'b1;
          out_re    = mem_re[cnt];
          out_im    = mem_im[cnt];
          out_last  = (cnt == 3'd7);
        end
        if (out_valid && out_ready) begin
          cnt_next = cnt + 3'd1;
          if (cnt == 3'd7) state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // Sample storage is deliberately left out of reset; a new frame overwrites every entry
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      mem_re[{cnt[0], cnt[1], cnt[2]}] <= in_re;
      mem_im[{cnt[0], cnt[1], cnt[2]}] <= in_im;
    end else if (rst_n && state == COMPUTE) begin
      mem_re[addr_lo] <= wb0_re;
      mem_im[addr_lo] <= wb0_im;
      mem_re[addr_hi] <= wb1_re;
      mem_im[addr_hi] <= wb1_im;
    end
  end

endmodule
